// File: rtl/pair_input_fifo.sv
// Output-stage register plus DEPTH-entry circular FIFO for coded bit-pair packets; 1-cycle bypass latency.
// in_ready drops when the FIFO holds DEPTH packets; packets offered then are dropped and flag overflow.
module pair_input_fifo #(
   parameter int PAIRS = 8,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [2*PAIRS-1:0]           data_in,
   input  logic                         renew,
   output logic                         out_valid,
   output logic [2*PAIRS-1:0]           bit_pairs,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         overflow
);

   localparam int W  = 2 * PAIRS;
   localparam int LW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          fifo_empty;
   logic          stage_free;
   logic          wr_acc;
   logic          bypass;
   logic          push;
   logic          pop;

   assign in_ready   = (level < FULL_LEVEL);
   assign fifo_empty = (level == '0);
   assign wr_acc     = in_valid && in_ready;
   // The output stage can take a packet when it is empty or being released this cycle.
   assign stage_free = renew || !out_valid;
   assign pop        = !fifo_empty && stage_free;
   assign bypass     = wr_acc && fifo_empty && stage_free;
   assign push       = wr_acc && !bypass;

   // Storage is not reset; pointers and level define which entries are live.
   always_ff @(posedge clk) begin
      if (rst && !flush && push) begin
         mem[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         level     <= '0;
         out_valid <= 1'b0;
         bit_pairs <= '0;
         overflow  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         if (push && !pop) begin
            level <= level + 1'b1;
         end else if (pop && !push) begin
            level <= level - 1'b1;
         end
         // pop and bypass are exclusive: pop needs a non-empty FIFO, bypass an empty one.
         if (pop) begin
            bit_pairs <= mem[rd_ptr];
            out_valid <= 1'b1;
         end else if (bypass) begin
            bit_pairs <= data_in;
            out_valid <= 1'b1;
         end else if (renew) begin
            out_valid <= 1'b0;
         end
         if (in_valid && !in_ready) begin
            overflow <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pair_input_fifo.sv
// Bench for pair_input_fifo (PAIRS=8, DEPTH=4): directed scenarios plus randomized traffic against a queue model.
module tb_pair_input_fifo;

   localparam int PAIRS = 8;
   localparam int DEPTH = 4;
   localparam int W     = 2 * PAIRS;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  data_in;
   logic          renew;
   logic          out_valid;
   logic [W-1:0]  bit_pairs;
   logic [2:0]    level;
   logic          overflow;
   logic [21:0]   dut_state;

   int errors = 0;
   int checks = 0;

   // Behavioural model: the current packet plus an ordered queue of waiting packets.
   logic          m_vld = 1'b0;
   logic [W-1:0]  m_cur = '0;
   logic          m_ovf = 1'b0;
   logic [W-1:0]  m_q[$];

   pair_input_fifo #(.PAIRS(PAIRS), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .renew     (renew),
      .out_valid (out_valid),
      .bit_pairs (bit_pairs),
      .level     (level),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   assign dut_state = {out_valid, bit_pairs, level, in_ready, overflow};

   function automatic logic [21:0] model_state();
      return {m_vld, m_cur, 3'(m_q.size()), (m_q.size() < DEPTH), m_ovf};
   endfunction

   // Apply one cycle of inputs, advance the model across the edge, return #1 after the edge.
   task automatic cycle(input logic r, input logic f, input logic v, input logic [W-1:0] d, input logic rn);
      logic rdy;
      rst = r; flush = f; in_valid = v; data_in = d; renew = rn;
      @(posedge clk);
      if (!r || f) begin
         m_vld = 1'b0; m_cur = '0; m_ovf = 1'b0; m_q.delete();
      end else begin
         rdy = (m_q.size() < DEPTH);
         if (v && !rdy) m_ovf = 1'b1;
         if (m_vld && rn) begin
            if (m_q.size() > 0) m_cur = m_q.pop_front();
            else m_vld = 1'b0;
         end else if (!m_vld && m_q.size() > 0) begin
            m_cur = m_q.pop_front();
            m_vld = 1'b1;
         end
         if (v && rdy) begin
            if (!m_vld && m_q.size() == 0) begin
               m_cur = d; m_vld = 1'b1;
            end else begin
               m_q.push_back(d);
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, '0, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b0);
      checks++;
      if (dut_state !== {1'b0, 16'h0000, 3'd0, 1'b1, 1'b0}) begin
         errors++; $display("FAIL reset_state: got %h want %h", dut_state, {1'b0, 16'h0000, 3'd0, 1'b1, 1'b0});
      end
   endtask

   task automatic test_bypass();
      logic [W-1:0] exp_pkt;
      exp_pkt = 16'hA5A5;
      cycle(1'b1, 1'b0, 1'b1, exp_pkt, 1'b0);
      checks++;
      if ({out_valid, bit_pairs, level} !== {1'b1, exp_pkt, 3'd0}) begin
         errors++; $display("FAIL bypass_out: got %h want %h", {out_valid, bit_pairs, level}, {1'b1, exp_pkt, 3'd0});
      end
      checks++;
      if ({bit_pairs[15:14], bit_pairs[13:12], bit_pairs[11:10], bit_pairs[9:8]} !== 8'b10_10_01_01) begin
         errors++; $display("FAIL bypass_pairs: got %b want 10100101", bit_pairs[15:8]);
      end
      checks++;
      if (dut_state !== model_state()) begin
         errors++; $display("FAIL bypass_model: got %h want %h", dut_state, model_state());
      end
   endtask

   task automatic test_queue_renew();
      cycle(1'b1, 1'b0, 1'b1, 16'h5A5A, 1'b0);
      checks++;
      if ({bit_pairs, level} !== {16'hA5A5, 3'd1}) begin
         errors++; $display("FAIL queue_level: got %h want %h", {bit_pairs, level}, {16'hA5A5, 3'd1});
      end
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if ({out_valid, bit_pairs, level} !== {1'b1, 16'h5A5A, 3'd0}) begin
         errors++; $display("FAIL renew_next: got %h want %h", {out_valid, bit_pairs, level}, {1'b1, 16'h5A5A, 3'd0});
      end
      checks++;
      if ({bit_pairs[15:14], bit_pairs[9:8]} !== 4'b01_10) begin
         errors++; $display("FAIL renew_pairs: got %b want 0110", {bit_pairs[15:14], bit_pairs[9:8]});
      end
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if ({out_valid, bit_pairs, level} !== {1'b0, 16'h5A5A, 3'd0}) begin
         errors++; $display("FAIL renew_empty: got %h want %h", {out_valid, bit_pairs, level}, {1'b0, 16'h5A5A, 3'd0});
      end
   endtask

   task automatic test_full_overflow();
      logic [W-1:0] exp_list [4];
      exp_list[0] = 16'h1111; exp_list[1] = 16'h2222; exp_list[2] = 16'h3333; exp_list[3] = 16'h4444;
      cycle(1'b1, 1'b0, 1'b1, 16'hAAAA, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b1, exp_list[i], 1'b0);
      checks++;
      if ({level, in_ready, overflow} !== {3'd4, 1'b0, 1'b0}) begin
         errors++; $display("FAIL full_level: got %h want %h", {level, in_ready, overflow}, {3'd4, 1'b0, 1'b0});
      end
      cycle(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b0);
      checks++;
      if ({bit_pairs, level, overflow} !== {16'hAAAA, 3'd4, 1'b1}) begin
         errors++; $display("FAIL overflow_drop: got %h want %h", {bit_pairs, level, overflow}, {16'hAAAA, 3'd4, 1'b1});
      end
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
         checks++;
         if ({out_valid, bit_pairs} !== {1'b1, exp_list[i]}) begin
            errors++; $display("FAIL drain_order[%0d]: got %h want %h", i, {out_valid, bit_pairs}, {1'b1, exp_list[i]});
         end
      end
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if ({out_valid, level, overflow} !== {1'b0, 3'd0, 1'b1}) begin
         errors++; $display("FAIL overflow_sticky: got %h want %h", {out_valid, level, overflow}, {1'b0, 3'd0, 1'b1});
      end
   endtask

   task automatic test_simultaneous();
      cycle(1'b1, 1'b0, 1'b1, 16'h7777, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 16'h0F0F, 1'b1);
      checks++;
      if ({out_valid, bit_pairs, level} !== {1'b1, 16'h0F0F, 3'd0}) begin
         errors++; $display("FAIL simul_empty: got %h want %h", {out_valid, bit_pairs, level}, {1'b1, 16'h0F0F, 3'd0});
      end
      cycle(1'b1, 1'b0, 1'b1, 16'h1001, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 16'h1002, 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 16'h1003, 1'b1);
      checks++;
      if ({bit_pairs, level} !== {16'h1001, 3'd2}) begin
         errors++; $display("FAIL simul_level2: got %h want %h", {bit_pairs, level}, {16'h1001, 3'd2});
      end
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if ({bit_pairs, level} !== {16'h1002, 3'd1}) begin
         errors++; $display("FAIL simul_order1: got %h want %h", {bit_pairs, level}, {16'h1002, 3'd1});
      end
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++;
      if ({bit_pairs, level} !== {16'h1003, 3'd0}) begin
         errors++; $display("FAIL simul_order2: got %h want %h", {bit_pairs, level}, {16'h1003, 3'd0});
      end
   endtask

   // Stimulus only: leaves one packet current, three queued and overflow set.
   task automatic fill_to_three();
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b1, 16'(16'h2000 + i), 1'b0);
      cycle(1'b1, 1'b0, 1'b1, 16'h2005, 1'b0);
      cycle(1'b1, 1'b0, 1'b0, '0, 1'b1);
   endtask

   task automatic test_mid_clear();
      for (int mode = 0; mode < 2; mode++) begin
         fill_to_three();
         checks++;
         if ({out_valid, level, overflow} !== {1'b1, 3'd3, 1'b1}) begin
            errors++; $display("FAIL clear_setup[%0d]: got %h want %h", mode, {out_valid, level, overflow}, {1'b1, 3'd3, 1'b1});
         end
         if (mode == 0) cycle(1'b0, 1'b0, 1'b1, 16'h9999, 1'b1);
         else cycle(1'b1, 1'b1, 1'b1, 16'h9999, 1'b1);
         checks++;
         if (dut_state !== {1'b0, 16'h0000, 3'd0, 1'b1, 1'b0}) begin
            errors++; $display("FAIL clear_state[%0d]: got %h want %h", mode, dut_state, {1'b0, 16'h0000, 3'd0, 1'b1, 1'b0});
         end
         cycle(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0);
         checks++;
         if ({out_valid, bit_pairs, level} !== {1'b1, 16'h1234, 3'd0}) begin
            errors++; $display("FAIL clear_restart[%0d]: got %h want %h", mode, {out_valid, bit_pairs, level}, {1'b1, 16'h1234, 3'd0});
         end
      end
   endtask

   task automatic test_random();
      int renew_pct;
      logic r, f, v, rn;
      for (int phase = 0; phase < 4; phase++) begin
         renew_pct = (phase == 0) ? 10 : (phase == 1) ? 50 : (phase == 2) ? 90 : 30;
         for (int n = 0; n < 200; n++) begin
            r  = ($urandom_range(0, 149) != 0);
            f  = ($urandom_range(0, 59) == 0);
            v  = ($urandom_range(0, 99) < 65);
            rn = ($urandom_range(0, 99) < renew_pct);
            cycle(r, f, v, 16'($urandom), rn);
            checks++;
            if (dut_state !== model_state()) begin
               errors++; $display("FAIL random[%0d.%0d]: got %h want %h", phase, n, dut_state, model_state());
            end
         end
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; data_in = '0; renew = 1'b0;
      test_reset();
      test_bypass();
      test_queue_renew();
      test_full_overflow();
      test_simultaneous();
      test_mid_clear();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pair_input_fifo.md
PAIR_INPUT_FIFO -- requirements
Module: pair_input_fifo

Interface
REQ-001 SHALL have parameter PAIRS, default 8: bit pairs per packet; packet width = 2*PAIRS; PAIRS >= 1.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries behind the output stage; power of 2, >= 2.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low (0 = reset).
REQ-005 flush  in  1  synchronous clear of all packets and the overflow flag.
REQ-006 in_valid  in  1  data_in carries a packet this cycle.
REQ-007 in_ready  out  1  a packet offered this cycle is accepted.
REQ-008 data_in  in  2*PAIRS  incoming coded packet.
REQ-009 renew  in  1  consumer has finished the current packet; advance to the next one.
REQ-010 out_valid  out  1  bit_pairs holds a live packet.
REQ-011 bit_pairs  out  2*PAIRS  current packet; pair k = bits [2k+1:2k]; pair PAIRS-1 is at the MSBs.
REQ-012 level  out  clog2(DEPTH+1)  packets held in the FIFO, excluding the output stage (0..DEPTH).
REQ-013 overflow  out  1  sticky flag: a packet offered while full was dropped.

Function
REQ-014 Storage SHALL be one output-stage register (bit_pairs/out_valid) plus a DEPTH-entry circular FIFO; read and write pointers SHALL wrap modulo DEPTH.
REQ-015 in_ready SHALL be combinational: in_ready = (level < DEPTH).
REQ-016 A write SHALL be accepted when in_valid && in_ready; a packet offered when in_ready=0 SHALL be dropped, with no state change except overflow <= 1.
REQ-017 Bypass: if the output stage is free (out_valid=0, or renew=1 with out_valid=1) and the FIFO is empty, an accepted packet SHALL load directly into bit_pairs on the same edge: out_valid=1 and level unchanged; latency is 1 cycle.
REQ-018 Otherwise an accepted packet SHALL be written at the FIFO tail and level SHALL increment.
REQ-019 renew with out_valid=1 and FIFO non-empty SHALL load the FIFO head into bit_pairs on the same edge; level SHALL decrement; out_valid SHALL stay 1.
REQ-020 renew with out_valid=1, FIFO empty and no accepted write SHALL clear out_valid; bit_pairs SHALL hold its last value.
REQ-021 renew with out_valid=0 SHALL be ignored.
REQ-022 Simultaneous renew and accepted write with a non-empty FIFO: the head SHALL go to the output stage and the new packet to the tail; level SHALL stay unchanged.
REQ-023 When out_valid=0 and the FIFO is non-empty (reachable only after a parameter-legal corner), the head SHALL load into the output stage on the next edge without renew.
REQ-024 Packets SHALL leave in strict arrival order; none SHALL be duplicated or lost, except drops per REQ-016.
REQ-025 overflow SHALL stay set until rst or flush.
REQ-026 flush=1 SHALL, on the edge, clear out_valid, level, both pointers and overflow; bit_pairs SHALL be zeroed; writes and renew in the same cycle SHALL be ignored.
REQ-027 Priority: rst > flush > normal operation.

Reset
REQ-028 rst=0 at an edge SHALL set out_valid=0, bit_pairs=0, level=0, pointers=0 and overflow=0; in_ready SHALL read 1 from the cycle after.
REQ-029 Reset mid-operation SHALL discard all held packets regardless of in_valid or renew.
REQ-030 FIFO storage contents need not be reset.

Verification (PAIRS=8, DEPTH=4)
REQ-031 Reset: rst=0 for 2 cycles, then 1 -> out_valid=0, bit_pairs=0000, level=0, in_ready=1, overflow=0.
REQ-032 Bypass: write A5A5 into an empty block -> next cycle out_valid=1, bit_pairs=A5A5 (pair7=10, pair6=10, pair5=01, pair4=01), level=0.
REQ-033 Queue/renew: with A5A5 current, write 5A5A -> level=1; pulse renew -> bit_pairs=5A5A (pair7=01, pair4=10), level=0; renew again -> out_valid=0.
REQ-034 Full/overflow: current packet held, write 1111, 2222, 3333, 4444 -> level=4, in_ready=0; offer FFFF -> dropped, overflow=1; four renews -> outputs 1111, 2222, 3333, 4444 in order, never FFFF.
REQ-035 Simultaneous events: renew and write 0F0F together with the FIFO empty -> bit_pairs=0F0F next cycle, level=0; repeat with level=2 -> level stays 2 and order is preserved.
REQ-036 Mid-operation clear: with level=3, assert rst=0 (then separately flush=1) for 1 cycle -> out_valid=0, level=0, overflow=0 next cycle; a subsequent write of 1234 appears after 1 cycle.
